// File: rtl/rv_shared_pipe_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated fixed-latency delay line.
package rv_shared_pipe_arbiter_pkg;

  // Index width that never collapses to zero, so a single requester still has a 1-bit tag.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_shared_pipe_arbiter_rr.sv
// Round-robin arbiter: the scan starts at the pointer, and the pointer moves past the winner only on an accepted grant.
module rv_rr_arbiter
  import rv_shared_pipe_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned REQW     = clog2_min1(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [REQW-1:0]     grant_index,
  output logic                grant_valid
);

  logic [REQW-1:0] ptr;
  logic [REQW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx = REQW'((32'(ptr) + k) % NUM_REQS);
      if (!grant_valid && requests[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_index = idx;
      end
    end
  end

  // The enable is the pipeline advance, not req_ready, so there is no combinational loop through the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (enable && grant_valid) begin
      ptr <= REQW'((32'(grant_index) + 1) % NUM_REQS);
    end
  end

endmodule

// File: rtl/rv_shared_pipe_arbiter.sv
// Shares one DEPTH-stage valid/data/tag delay line among NUM_REQS requesters; the whole line freezes on output back-pressure.
module rv_shared_pipe_arbiter
  import rv_shared_pipe_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned REQW     = clog2_min1(NUM_REQS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQS-1:0]         req_valid,
  input  logic [NUM_REQS*DATAW-1:0]   req_data,
  output logic [NUM_REQS-1:0]         req_ready,
  output logic                        rsp_valid,
  output logic [DATAW-1:0]            rsp_data,
  output logic [REQW-1:0]             rsp_tag,
  input  logic                        rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned OCCW = $clog2(DEPTH + 1);

  logic                advance;
  logic [NUM_REQS-1:0] grant;
  logic [REQW-1:0]     grant_idx;
  logic                grant_valid;
  logic [DATAW-1:0]    grant_data;

  logic [DEPTH-1:0]    stage_valid;
  logic [DATAW-1:0]    stage_data [DEPTH];
  logic [REQW-1:0]     stage_tag  [DEPTH];
  logic [DEPTH-1:0]    next_valid;
  logic [OCCW-1:0]     next_occ;

  assign advance = ~(rsp_valid & ~rsp_ready);

  rv_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .REQW     (REQW)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (req_valid),
    .enable      (advance),
    .grant       (grant),
    .grant_index (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant & {NUM_REQS{advance}};

  always_comb begin
    grant_data = '0;
    if (grant_valid) begin
      grant_data = req_data[32'(grant_idx)*DATAW +: DATAW];
    end
  end

  // Empty stages shift like full ones, so the occupancy is taken from the post-edge valid vector.
  always_comb begin
    next_valid = stage_valid;
    if (advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        next_valid[k] = stage_valid[k-1];
      end
      next_valid[0] = grant_valid;
    end
    next_occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      next_occ = next_occ + OCCW'(next_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      occupancy   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_data[k] <= '0;
        stage_tag[k]  <= '0;
      end
    end else begin
      stage_valid <= next_valid;
      occupancy   <= next_occ;
      if (advance) begin
        for (int unsigned k = 1; k < DEPTH; k++) begin
          stage_data[k] <= stage_data[k-1];
          stage_tag[k]  <= stage_tag[k-1];
        end
        stage_data[0] <= grant_data;
        stage_tag[0]  <= grant_idx;
      end
    end
  end

  assign rsp_valid = stage_valid[DEPTH-1];
  assign rsp_data  = stage_data[DEPTH-1];
  assign rsp_tag   = stage_tag[DEPTH-1];

endmodule

// File: doc/rv_shared_pipe_arbiter.md
Name: rv_shared_pipe_arbiter

Overview:
Shares one fixed-latency, enable-gated delay line among NUM_REQS requesters.
- Round-robin arbitration picks one requester per cycle.
- The winning payload and its requester index (tag) are pushed into a DEPTH-stage valid/data/tag pipeline.
- The whole pipeline freezes when the consumer back-pressures the output.
- Sits between warp-level issue sources and a shared multi-cycle unit, so responses carry the tag for return routing.

Parameters:
- NUM_REQS, 4, number of requesters (>=1).
- DATAW, 8, payload width per requester.
- DEPTH, 2, pipeline stages = fixed latency in cycles (>=1).
- REQW, $clog2(NUM_REQS) (min 1), tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  packed payloads; requester i occupies bits [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester accept; at most one bit high per cycle.
- rsp_valid  out  1  last stage holds a valid entry.
- rsp_data  out  DATAW  last-stage payload.
- rsp_tag  out  REQW  last-stage requester index.
- rsp_ready  in  1  consumer accepts the response.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset (clk edge with reset=1):
  - All stage valid bits, data and tags clear to 0.
  - RR pointer clears to 0.
  - Outputs after reset: rsp_valid=0, rsp_data=0, rsp_tag=0, occupancy=0, req_ready=0.
  - Reset mid-operation discards all in-flight entries; no response is produced for them.
- Stall and advance:
  - stall = rsp_valid & ~rsp_ready; advance = ~stall.
  - On a clk edge with advance=1: stage[k] <= stage[k-1] for k=DEPTH-1..1, and stage[0] <= {grant_any, grant_data, grant_idx}.
  - On stall: every stage holds its value.
  - No bubble collapsing: empty stages shift like full ones, so latency is always exactly DEPTH advancing cycles.
- Arbitration (combinational):
  - Scan from RR pointer p upward modulo NUM_REQS; the first i with req_valid[i]=1 wins.
  - req_ready[i] = win[i] & advance.
  - Handshake fires when req_valid[i] & req_ready[i].
  - On a fired handshake, p <= (i+1) mod NUM_REQS. Otherwise p holds, including during stall.
  - The arbiter must not depend on req_ready combinationally (no loop).
  - A requester may drop valid while not granted; no fairness penalty applies.
- Response:
  - rsp_valid/rsp_data/rsp_tag come directly from stage[DEPTH-1]; they are registered, with no comb path from req_* inputs.
  - Output handshake completes when rsp_valid & rsp_ready.
  - Simultaneous output handshake and new grant in one cycle is allowed, giving 1 transfer/cycle throughput.
- occupancy:
  - Registered popcount of stage valid bits after each edge.
  - Range 0..DEPTH.
- Latency:
  - Request accepted at edge t appears on rsp_* after edge t+DEPTH-1 (visible in cycle t+DEPTH), given no stalls.
  - Each stall cycle adds one cycle.
- Boundary cases:
  - NUM_REQS=1: tag constant 0, pointer unused.
  - DEPTH=1: single stage; rsp equals stage 0.
  - All req_valid=0 with advance=1: a bubble enters stage 0.

Decomposition:
- Shared header (common defines): clog2-with-min-1 helper macro and payload/tag field packing macros.
- Sub-module rv_rr_arbiter (NUM_REQS): inputs requests and a pointer-update enable; outputs one-hot grant, grant index and grant_valid. It owns the RR pointer register.
- The stage pipeline stays inline.

Test Plan:
- Reset then single requester: NUM_REQS=4, DEPTH=2, req_valid=0001, data0=0xA5, rsp_ready=1 -> req_ready[0]=1 in cycle 0; rsp_valid=1, rsp_data=0xA5, rsp_tag=0 in cycle 2; occupancy peaks at 1.
- Full contention: req_valid=1111 held 8 cycles, data_i=0x10+i, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; rsp_tag sequence identical, delayed 2 cycles; occupancy=2 in steady state.
- Back-pressure: pipeline full with tags 1,2, then rsp_ready=0 for 3 cycles -> req_ready=0000, stage contents frozen, rsp_tag=1 held, pointer unchanged; after rsp_ready=1, tags 1,2 drain in order with no loss or duplication.
- Sparse traffic: req_valid pulses 0100 in one cycle, then 0000 for 3 cycles -> exactly one response, tag=2, 2 cycles later; occupancy returns to 0; the following grant to a 1111 request goes to requester 3.
- Reset mid-flight: two entries in flight, reset asserted for 1 cycle -> rsp_valid=0 and occupancy=0 next cycle; discarded tags never appear; pointer restarts at 0.
- Simultaneous drain and fill under a random rsp_ready pattern (seeded) -> scoreboard per tag: in-order, count-preserving, each response at accept time + DEPTH + stall cycles.
